// File: rtl/fifo_inline_checker_if.sv
// Signal bundle between a FIFO under test and its inline checker.
// The master side drives stimulus and DUT responses; the checker only observes.
interface fifo_inline_checker_if #(
    parameter int FIFO_WIDTH = 16
);
    logic                  wr_en;
    logic                  rd_en;
    logic [FIFO_WIDTH-1:0] data_in;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  empty;
    logic                  almostfull;
    logic                  almostempty;

    modport master (
        output wr_en, rd_en, data_in, data_out, wr_ack, overflow, underflow,
               full, empty, almostfull, almostempty
    );

    modport slave (
        input  wr_en, rd_en, data_in, data_out, wr_ack, overflow, underflow,
               full, empty, almostfull, almostempty
    );
endinterface

// File: rtl/fifo_inline_checker.sv
// Inline scoreboard for a synchronous FIFO: shadow reference model plus
// per-cycle comparison of the DUT's registered outputs and status flags.
module fifo_inline_checker #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              chk_en,
    input  logic                              clr,
    fifo_inline_checker_if.slave              bus,
    output logic [CNT_W-1:0]                  correct_count,
    output logic [CNT_W-1:0]                  error_count,
    output logic [7:0]                        err_sticky,
    output logic                              err_pulse,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   model_count
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  exp_wr_ack;
    logic                  exp_overflow;
    logic                  exp_underflow;
    logic [FIFO_WIDTH-1:0] exp_data_out;
    logic                  last_rd;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [7:0]            mism;

    assign model_count = count;

    // Comparisons use the model state as it stands before this edge's update.
    always_comb begin
        wr_acc  = bus.wr_en && (count != DEPTH_C);
        rd_acc  = bus.rd_en && (count != '0);
        mism    = '0;
        mism[0] = last_rd && (bus.data_out != exp_data_out);
        mism[1] = bus.wr_ack      != exp_wr_ack;
        mism[2] = bus.overflow    != exp_overflow;
        mism[3] = bus.underflow   != exp_underflow;
        mism[4] = bus.full        != (count == DEPTH_C);
        mism[5] = bus.empty       != (count == '0);
        mism[6] = bus.almostfull  != (count == AFULL_C);
        mism[7] = bus.almostempty != (count == ONE_C);
    end

    // Shadow storage carries no reset; stale words are never read back.
    always_ff @(posedge clk) begin
        if (chk_en && wr_acc) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            exp_wr_ack    <= 1'b0;
            exp_overflow  <= 1'b0;
            exp_underflow <= 1'b0;
            exp_data_out  <= '0;
            last_rd       <= 1'b0;
        end else if (chk_en) begin
            exp_wr_ack    <= wr_acc;
            exp_overflow  <= bus.wr_en && !wr_acc;
            exp_underflow <= bus.rd_en && (count == '0);
            last_rd       <= rd_acc;
            if (rd_acc) begin
                exp_data_out <= mem[rd_ptr];
                rd_ptr       <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
            end
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
            end
            if (wr_acc && !rd_acc) begin
                count <= count + ONE_C;
            end else if (rd_acc && !wr_acc) begin
                count <= count - ONE_C;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            correct_count <= '0;
            error_count   <= '0;
            err_sticky    <= '0;
            err_pulse     <= 1'b0;
        end else begin
            err_pulse <= chk_en && (mism != '0);
            if (clr) begin
                correct_count <= '0;
                error_count   <= '0;
                err_sticky    <= '0;
            end else if (chk_en) begin
                err_sticky <= err_sticky | mism;
                if (mism == '0) begin
                    if (correct_count != '1) correct_count <= correct_count + CNT_W'(1);
                end else begin
                    if (error_count != '1) error_count <= error_count + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_inline_checker.sv
// Directed bench: a behavioural FIFO plays the DUT, faults are injected on its
// outputs, and checker results are compared against hand-computed values.
module tb_fifo_inline_checker;
    logic clk;
    logic rst_n;
    logic chk_en;
    logic clr;
    int   checks;
    int   failures;

    logic force_full_zero;
    logic force_udf_zero;
    logic force_data_xor;

    fifo_inline_checker_if #(.FIFO_WIDTH(16)) bus ();

    logic [15:0] cc;
    logic [15:0] ec;
    logic [7:0]  sticky;
    logic        pulse;
    logic [3:0]  mc;

    logic [3:0]  cc_s;
    logic [3:0]  ec_s;
    logic [7:0]  sticky_s;
    logic        pulse_s;
    logic [3:0]  mc_s;

    fifo_inline_checker #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .clr(clr), .bus(bus),
        .correct_count(cc), .error_count(ec), .err_sticky(sticky),
        .err_pulse(pulse), .model_count(mc)
    );

    fifo_inline_checker #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .clr(clr), .bus(bus),
        .correct_count(cc_s), .error_count(ec_s), .err_sticky(sticky_s),
        .err_pulse(pulse_s), .model_count(mc_s)
    );

    // Behavioural stand-in for the FIFO being checked (depth 8).
    logic [15:0] sf_mem [8];
    int          sf_cnt;
    int          sf_wp;
    int          sf_rp;
    logic        sf_ack;
    logic        sf_ovf;
    logic        sf_udf;
    logic [15:0] sf_dout;
    logic        sf_w;
    logic        sf_r;

    assign sf_w = bus.wr_en && (sf_cnt < 8);
    assign sf_r = bus.rd_en && (sf_cnt > 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sf_cnt  <= 0;
            sf_wp   <= 0;
            sf_rp   <= 0;
            sf_ack  <= 1'b0;
            sf_ovf  <= 1'b0;
            sf_udf  <= 1'b0;
            sf_dout <= 16'h0;
        end else begin
            sf_ack <= sf_w;
            sf_ovf <= bus.wr_en && !sf_w;
            sf_udf <= bus.rd_en && (sf_cnt == 0);
            if (sf_w) begin
                sf_mem[sf_wp] <= bus.data_in;
                sf_wp         <= (sf_wp + 1) % 8;
            end
            if (sf_r) begin
                sf_dout <= sf_mem[sf_rp];
                sf_rp   <= (sf_rp + 1) % 8;
            end
            sf_cnt <= sf_cnt + (sf_w ? 1 : 0) - (sf_r ? 1 : 0);
        end
    end

    assign bus.wr_ack      = sf_ack;
    assign bus.overflow    = sf_ovf;
    assign bus.underflow   = sf_udf && !force_udf_zero;
    assign bus.data_out    = force_data_xor ? (sf_dout ^ 16'hFFFF) : sf_dout;
    assign bus.full        = (sf_cnt == 8) && !force_full_zero;
    assign bus.empty       = (sf_cnt == 0);
    assign bus.almostfull  = (sf_cnt == 7);
    assign bus.almostempty = (sf_cnt == 1);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst_n           = 1'b0;
        chk_en          = 1'b0;
        clr             = 1'b0;
        force_full_zero = 1'b0;
        force_udf_zero  = 1'b0;
        force_data_xor  = 1'b0;
        bus.wr_en       = 1'b0;
        bus.rd_en       = 1'b0;
        bus.data_in     = 16'h0;
        tick();
        tick();
        check("rst_correct", 32'(cc), 0);
        check("rst_error", 32'(ec), 0);
        check("rst_model_count", 32'(mc), 0);
        check("rst_sticky", 32'(sticky), 0);
        check("rst_pulse", 32'(pulse), 0);

        // Idle with a well-behaved FIFO
        rst_n  = 1'b1;
        chk_en = 1'b1;
        repeat (3) tick();
        check("idle_correct", 32'(cc), 3);
        check("idle_error", 32'(ec), 0);
        check("idle_model_count", 32'(mc), 0);

        // Nine writes into depth 8, then drain
        for (int i = 1; i <= 9; i++) begin
            bus.wr_en   = 1'b1;
            bus.data_in = 16'(i);
            tick();
            if (i == 8) check("fill_model_count", 32'(mc), 8);
        end
        check("overflow_model_count", 32'(mc), 8);
        check("overflow_error", 32'(ec), 0);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b1;
        repeat (8) tick();
        bus.rd_en = 1'b0;
        tick();
        check("drain_correct", 32'(cc), 21);
        check("drain_error", 32'(ec), 0);
        check("drain_model_count", 32'(mc), 0);

        // Simultaneous write/read at empty and at full
        bus.wr_en   = 1'b1;
        bus.rd_en   = 1'b1;
        bus.data_in = 16'h00AA;
        tick();
        check("simul_empty_count", 32'(mc), 1);
        bus.rd_en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.data_in = 16'(16'h10 + i);
            tick();
        end
        check("simul_fill_count", 32'(mc), 8);
        bus.rd_en   = 1'b1;
        bus.data_in = 16'h00BB;
        tick();
        check("simul_full_count", 32'(mc), 7);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        tick();
        check("simul_error", 32'(ec), 0);
        check("simul_correct", 32'(cc), 31);
        bus.rd_en = 1'b1;
        repeat (7) tick();
        bus.rd_en = 1'b0;
        tick();
        check("simul_drain_correct", 32'(cc), 39);
        check("simul_drain_count", 32'(mc), 0);

        // Full flag forced low at count 8
        bus.wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.data_in = 16'(16'h20 + i);
            tick();
        end
        bus.wr_en       = 1'b0;
        force_full_zero = 1'b1;
        tick();
        check("full_inj_sticky", 32'(sticky), 32'h10);
        check("full_inj_error", 32'(ec), 1);
        check("full_inj_pulse", 32'(pulse), 1);
        check("full_inj_correct", 32'(cc), 47);
        force_full_zero = 1'b0;
        tick();
        check("full_inj_pulse_end", 32'(pulse), 0);
        check("full_inj_correct2", 32'(cc), 48);
        bus.rd_en = 1'b1;
        repeat (8) tick();
        bus.rd_en = 1'b0;
        tick();
        check("full_drain_correct", 32'(cc), 57);

        // Read on empty, then the DUT drops its underflow
        bus.rd_en = 1'b1;
        tick();
        check("udf_clean_correct", 32'(cc), 58);
        bus.rd_en      = 1'b0;
        force_udf_zero = 1'b1;
        tick();
        check("udf_inj_sticky", 32'(sticky), 32'h18);
        check("udf_inj_error", 32'(ec), 2);
        check("udf_inj_pulse", 32'(pulse), 1);
        force_udf_zero = 1'b0;
        tick();
        check("udf_after_correct", 32'(cc), 59);

        // Corrupted read data; ignored once no read preceded
        bus.wr_en   = 1'b1;
        bus.data_in = 16'h5A5A;
        tick();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en      = 1'b0;
        force_data_xor = 1'b1;
        tick();
        check("data_inj_sticky", 32'(sticky), 32'h19);
        check("data_inj_error", 32'(ec), 3);
        check("data_inj_correct", 32'(cc), 61);
        tick();
        check("data_noread_correct", 32'(cc), 62);
        check("data_noread_pulse", 32'(pulse), 0);
        force_data_xor = 1'b0;

        // Clear with a non-empty model
        bus.wr_en   = 1'b1;
        bus.data_in = 16'h1111;
        tick();
        bus.data_in = 16'h2222;
        tick();
        bus.wr_en = 1'b0;
        check("pre_clr_correct", 32'(cc), 64);
        check("sat_correct", 32'(cc_s), 15);
        check("sat_error", 32'(ec_s), 3);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_correct", 32'(cc), 0);
        check("clr_error", 32'(ec), 0);
        check("clr_sticky", 32'(sticky), 0);
        check("clr_model_count", 32'(mc), 2);
        check("clr_sat_correct", 32'(cc_s), 0);
        bus.rd_en = 1'b1;
        repeat (2) tick();
        bus.rd_en = 1'b0;
        tick();
        check("post_clr_correct", 32'(cc), 3);

        // Checker disabled while the FIFO keeps moving
        chk_en      = 1'b0;
        bus.wr_en   = 1'b1;
        bus.data_in = 16'h0033;
        repeat (2) tick();
        bus.wr_en = 1'b0;
        tick();
        check("dis_model_count", 32'(mc), 0);
        check("dis_correct", 32'(cc), 3);
        check("dis_error", 32'(ec), 0);
        check("dis_pulse", 32'(pulse), 0);

        rst_n = 1'b0;
        tick();
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Asynchronous reset with three words in flight
        bus.wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.data_in = 16'(16'h41 + i);
            tick();
        end
        bus.wr_en = 1'b0;
        check("midop_model_count", 32'(mc), 3);
        rst_n = 1'b0;
        #1;
        check("async_model_count", 32'(mc), 0);
        check("async_correct", 32'(cc), 0);
        check("async_error", 32'(ec), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_correct", 32'(cc), 1);
        check("post_rst_error", 32'(ec), 0);

        // Saturation of a 4-bit counter
        repeat (20) tick();
        check("long_correct", 32'(cc), 21);
        check("sat4_correct", 32'(cc_s), 15);
        check("sat4_error", 32'(ec_s), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
